// File: rtl/chime_pkg.sv
// Shared state encoding and widths for the doorbell chime sequencer.
package chime_pkg;

    localparam int STATE_W = 3;
    localparam int REP_W   = 8;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_PLAY_A = 3'd1;
    localparam logic [STATE_W-1:0] ST_PLAY_B = 3'd2;
    localparam logic [STATE_W-1:0] ST_GAP    = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/chime_sequencer_dwell_timer.sv
// Loadable saturating down-counter; the owner decides when to load and reads only the zero flag.
module dwell_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/chime_sequencer.sv
// Doorbell chime sequencer: drives the tone mux sel/sys_on lines through A-B repetitions with gaps.
module chime_sequencer
    import chime_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int DUR_A   = 3,
    parameter int DUR_B   = 2,
    parameter int GAP_LEN = 1,
    parameter int REPEATS = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               press,
    output logic               sel,
    output logic               sys_on,
    output logic               busy,
    output logic               done,
    output logic [REP_W-1:0]   rep_idx,
    output logic [STATE_W-1:0] state_dbg
);

    localparam logic [CNT_W-1:0] LOAD_A   = CNT_W'(DUR_A - 1);
    localparam logic [CNT_W-1:0] LOAD_B   = CNT_W'(DUR_B - 1);
    localparam logic [CNT_W-1:0] LOAD_GAP = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;
    localparam logic [REP_W-1:0] LAST_REP = REP_W'(REPEATS - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic               pending_q, pending_d;
    logic               sel_q, sys_on_q, busy_q, done_q;
    logic               load;
    logic [CNT_W-1:0]   load_val;
    logic               dwell_zero;

    dwell_timer #(.CNT_W(CNT_W)) u_dwell (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .value_i (load_val),
        .zero_o  (dwell_zero)
    );

    always_comb begin
        state_d   = state_q;
        rep_d     = rep_q;
        pending_d = pending_q | (press && (state_q != ST_IDLE));
        load      = 1'b0;
        load_val  = '0;
        if (!enable) begin
            // Power loss aborts silently: no done pulse, queued request dropped.
            state_d   = ST_IDLE;
            rep_d     = '0;
            pending_d = 1'b0;
            load      = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A pending request can survive a press that landed in DONE.
                    if (press || pending_q) begin
                        state_d   = ST_PLAY_A;
                        rep_d     = '0;
                        pending_d = 1'b0;
                        load      = 1'b1;
                        load_val  = LOAD_A;
                    end
                end
                ST_PLAY_A: begin
                    if (dwell_zero) begin
                        state_d  = ST_PLAY_B;
                        load     = 1'b1;
                        load_val = LOAD_B;
                    end
                end
                ST_PLAY_B: begin
                    if (dwell_zero) begin
                        if (rep_q == LAST_REP) begin
                            state_d = ST_DONE;
                        end else if (GAP_LEN == 0) begin
                            state_d  = ST_PLAY_A;
                            rep_d    = rep_q + 1'b1;
                            load     = 1'b1;
                            load_val = LOAD_A;
                        end else begin
                            state_d  = ST_GAP;
                            load     = 1'b1;
                            load_val = LOAD_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (dwell_zero) begin
                        state_d  = ST_PLAY_A;
                        rep_d    = rep_q + 1'b1;
                        load     = 1'b1;
                        load_val = LOAD_A;
                    end
                end
                ST_DONE: begin
                    rep_d = '0;
                    if (pending_q) begin
                        state_d   = ST_PLAY_A;
                        pending_d = press;
                        load      = 1'b1;
                        load_val  = LOAD_A;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    rep_d     = '0;
                    pending_d = 1'b0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rep_q     <= '0;
            pending_q <= 1'b0;
            sel_q     <= 1'b0;
            sys_on_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rep_q     <= rep_d;
            pending_q <= pending_d;
            sel_q     <= (state_d == ST_PLAY_B) || (state_d == ST_GAP);
            sys_on_q  <= (state_d == ST_PLAY_A) || (state_d == ST_PLAY_B);
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign sel       = sel_q;
    assign sys_on    = sys_on_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign rep_idx   = rep_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_chime_sequencer.sv
// Table-driven bench for chime_sequencer: default build plus a gapless three-repeat build.
module tb_chime_sequencer;
    import chime_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       en1, pr1, sel1, on1, busy1, done1;
    logic [7:0] rep1;
    logic [2:0] st1;
    logic       en4, pr4, sel4, on4, busy4, done4;
    logic [7:0] rep4;
    logic [2:0] st4;

    chime_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .enable(en1), .press(pr1),
        .sel(sel1), .sys_on(on1), .busy(busy1), .done(done1),
        .rep_idx(rep1), .state_dbg(st1)
    );

    chime_sequencer #(.DUR_A(1), .DUR_B(1), .GAP_LEN(0), .REPEATS(3)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .enable(en4), .press(pr4),
        .sel(sel4), .sys_on(on4), .busy(busy4), .done(done4),
        .rep_idx(rep4), .state_dbg(st4)
    );

    typedef struct {
        logic       en;
        logic       press;
        logic       sel;
        logic       sys_on;
        logic       busy;
        logic       done;
        logic [7:0] rep;
        logic [2:0] st;
    } vec_t;

    vec_t tbl[40];
    int   tbl_n;
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input int cyc, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic build_idle(input int n);
        tbl_n = n;
        for (int i = 0; i < n; i++) begin
            tbl[i] = '{en: 1'b1, press: 1'b0, sel: 1'b0, sys_on: 1'b0, busy: 1'b0,
                       done: 1'b0, rep: 8'd0, st: ST_IDLE};
        end
    endtask

    task automatic set_out(input int i, input logic s, input logic on, input logic b,
                           input logic d, input logic [7:0] r, input logic [2:0] st);
        if (i < tbl_n) begin
            tbl[i].sel = s; tbl[i].sys_on = on; tbl[i].busy = b;
            tbl[i].done = d; tbl[i].rep = r; tbl[i].st = st;
        end
    endtask

    // Default chime: A x3, B x2, gap, A x3, B x2, done.
    task automatic put_chime(input int f);
        for (int k = 0; k < 3; k++) set_out(f + k,      1'b0, 1'b1, 1'b1, 1'b0, 8'd0, ST_PLAY_A);
        for (int k = 3; k < 5; k++) set_out(f + k,      1'b1, 1'b1, 1'b1, 1'b0, 8'd0, ST_PLAY_B);
        set_out(f + 5,                                  1'b1, 1'b0, 1'b1, 1'b0, 8'd0, ST_GAP);
        for (int k = 6; k < 9; k++) set_out(f + k,      1'b0, 1'b1, 1'b1, 1'b0, 8'd1, ST_PLAY_A);
        for (int k = 9; k < 11; k++) set_out(f + k,     1'b1, 1'b1, 1'b1, 1'b0, 8'd1, ST_PLAY_B);
        set_out(f + 11,                                 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, ST_DONE);
    endtask

    task automatic run_table(input string tag, input int which);
        logic       a_sel, a_on, a_busy, a_done;
        logic [7:0] a_rep;
        logic [2:0] a_st;
        for (int i = 0; i < tbl_n; i++) begin
            @(posedge clk);
            #1;
            if (which == 1) begin
                en1 = tbl[i].en; pr1 = tbl[i].press;
            end else begin
                en4 = tbl[i].en; pr4 = tbl[i].press;
            end
            @(negedge clk);
            if (which == 1) begin
                a_sel = sel1; a_on = on1; a_busy = busy1; a_done = done1; a_rep = rep1; a_st = st1;
            end else begin
                a_sel = sel4; a_on = on4; a_busy = busy4; a_done = done4; a_rep = rep4; a_st = st4;
            end
            check({tag, ".sel"},     i, 32'(a_sel),  32'(tbl[i].sel));
            check({tag, ".sys_on"},  i, 32'(a_on),   32'(tbl[i].sys_on));
            check({tag, ".busy"},    i, 32'(a_busy), 32'(tbl[i].busy));
            check({tag, ".done"},    i, 32'(a_done), 32'(tbl[i].done));
            check({tag, ".rep_idx"}, i, 32'(a_rep),  32'(tbl[i].rep));
            check({tag, ".state"},   i, 32'(a_st),   32'(tbl[i].st));
        end
        @(posedge clk);
        #1;
        en1 = 1'b1; pr1 = 1'b0; en4 = 1'b1; pr4 = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        en1 = 1'b1; pr1 = 1'b0; en4 = 1'b1; pr4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        en1 = 1'b1; pr1 = 1'b0; en4 = 1'b1; pr4 = 1'b0;
        #3;
        check("reset.sel",     0, 32'(sel1),  0);
        check("reset.sys_on",  0, 32'(on1),   0);
        check("reset.busy",    0, 32'(busy1), 0);
        check("reset.done",    0, 32'(done1), 0);
        check("reset.rep_idx", 0, 32'(rep1),  0);
        check("reset.state",   0, 32'(st1),   32'(ST_IDLE));
        check("reset4.busy",   0, 32'(busy4), 0);

        // Single chime from one press.
        do_reset();
        build_idle(15);
        put_chime(1);
        tbl[0].press = 1'b1;
        run_table("basic", 1);

        // One queued retrigger; the third press is absorbed.
        do_reset();
        build_idle(27);
        put_chime(1);
        put_chime(13);
        tbl[0].press = 1'b1; tbl[5].press = 1'b1; tbl[8].press = 1'b1;
        run_table("retrig", 1);

        // Enable drop mid PLAY_A of rep 1, then a press while disabled.
        do_reset();
        build_idle(13);
        put_chime(1);
        for (int i = 9; i < 13; i++) set_out(i, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, ST_IDLE);
        tbl[0].press = 1'b1;
        for (int i = 8; i < 13; i++) tbl[i].en = 1'b0;
        tbl[10].press = 1'b1;
        run_table("abort", 1);

        // Gapless build: sel alternates every cycle with sys_on held high.
        do_reset();
        build_idle(9);
        tbl[0].press = 1'b1;
        set_out(1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, ST_PLAY_A);
        set_out(2, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, ST_PLAY_B);
        set_out(3, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, ST_PLAY_A);
        set_out(4, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, ST_PLAY_B);
        set_out(5, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2, ST_PLAY_A);
        set_out(6, 1'b1, 1'b1, 1'b1, 1'b0, 8'd2, ST_PLAY_B);
        set_out(7, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2, ST_DONE);
        run_table("nogap", 4);

        // Press coinciding with enable falling while idle.
        do_reset();
        build_idle(4);
        tbl[0].en = 1'b0;
        tbl[0].press = 1'b1;
        run_table("en_vs_press", 1);

        // Async reset in the middle of PLAY_B with a request pending.
        do_reset();
        build_idle(5);
        put_chime(1);
        tbl[0].press = 1'b1;
        tbl[2].press = 1'b1;
        run_table("pre_rst", 1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst.sel",     0, 32'(sel1),  0);
        check("async_rst.sys_on",  0, 32'(on1),   0);
        check("async_rst.busy",    0, 32'(busy1), 0);
        check("async_rst.done",    0, 32'(done1), 0);
        check("async_rst.rep_idx", 0, 32'(rep1),  0);
        check("async_rst.state",   0, 32'(st1),   32'(ST_IDLE));
        #1;
        rst_n = 1'b1;
        build_idle(3);
        run_table("post_rst_idle", 1);
        build_idle(7);
        put_chime(1);
        tbl[0].press = 1'b1;
        run_table("post_rst_fresh", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
